// File: rtl/sfcw_pkg.sv
// ---------------------------------------------------------------------------
// sfcw_pkg : shared types and default constants for the SFCW sweep sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sfcw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PROG   = 3'd1,
    SETTLE = 3'd2,
    DWELL  = 3'd3,
    NEXT   = 3'd4
  } state_t;

  localparam int LO2_PERIOD = 20;

  localparam int DEF_N_STEPS     = 128;
  localparam int DEF_STEP_W      = 8;
  localparam int DEF_SETTLE_CYC  = 200;
  localparam int DEF_DWELL_CYC   = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_ACK_TIMEOUT = 4096;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfcw_sweep_ctrl_cycle_cnt.sv
// ---------------------------------------------------------------------------
// sfcw_cycle_cnt : loadable down-counter with zero flags (current and next)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sfcw_cycle_cnt
  import sfcw_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             zero_next
);

  logic [CNT_W-1:0] count_d;

  // Saturates at zero so an idle counter keeps reporting zero.
  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count != '0)) begin
      count_d = count - CNT_W'(1);
    end
  end

  assign zero      = (count == '0);
  assign zero_next = (count_d == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sfcw_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sfcw_sweep_ctrl : stepped-frequency CW sweep sequencer (PLL req/settle/dwell)
// Optional ack timeout enabled by defining SFCW_ACK_TIMEOUT_EN. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sfcw_sweep_ctrl
  import sfcw_pkg::*;
#(
  parameter int N_STEPS     = DEF_N_STEPS,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int DWELL_CYC   = DEF_DWELL_CYC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  output logic              step_req,
  output logic [STEP_W-1:0] step_idx,
  input  logic              step_ack,
  output logic              lo2_rst_n,
  output logic              acq_valid,
  output logic              acq_last,
  output logic              step_done,
  output logic              sweep_done,
  output logic              busy,
  output logic              err
);

  localparam int CNT_NEED = max3(SETTLE_CYC, DWELL_CYC, ACK_TIMEOUT) - 1;

  generate
    if (longint'(CNT_NEED) >= (64'd1 << CNT_W)) begin : g_cnt_too_narrow
      $error("sfcw_sweep_ctrl: CNT_W too small for settle/dwell/timeout counts");
    end
    if ((DWELL_CYC % LO2_PERIOD) != 0) begin : g_dwell_not_lo2_multiple
      $error("sfcw_sweep_ctrl: DWELL_CYC must be a multiple of the LO2 period");
    end
    if (longint'(N_STEPS - 1) >= (64'd1 << STEP_W)) begin : g_step_w_too_narrow
      $error("sfcw_sweep_ctrl: STEP_W too small for N_STEPS");
    end
  endgenerate

  state_t            state;
  state_t            nxt;
  logic [STEP_W-1:0] idx_nxt;
  logic              last_step;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cnt_count;
  logic              cnt_zero;
  logic              cnt_zero_next;
  logic              timeout;

  sfcw_cycle_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .dec       (cnt_dec),
    .load_val  (cnt_val),
    .count     (cnt_count),
    .zero      (cnt_zero),
    .zero_next (cnt_zero_next)
  );

  assign last_step = (step_idx == STEP_W'(N_STEPS - 1));

  always_comb begin
    nxt      = state;
    idx_nxt  = step_idx;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt     = PROG;
          idx_nxt = '0;
        end
      end
      PROG: begin
        if (step_ack) begin
          nxt      = SETTLE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETTLE_CYC - 1);
        end
`ifdef SFCW_ACK_TIMEOUT_EN
        else if (cnt_zero) begin
          nxt     = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      SETTLE: begin
        if (cnt_zero) begin
          nxt      = DWELL;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(DWELL_CYC - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DWELL: begin
        if (cnt_zero) begin
          nxt = NEXT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      NEXT: begin
        if (last_step) begin
          idx_nxt = '0;
          nxt     = continuous ? PROG : IDLE;
        end else begin
          idx_nxt = step_idx + STEP_W'(1);
          nxt     = PROG;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase

    // Abort beats everything except reset; the step index is left as-is.
    if (stop) begin
      nxt      = IDLE;
      idx_nxt  = step_idx;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      timeout  = 1'b0;
    end

`ifdef SFCW_ACK_TIMEOUT_EN
    if ((nxt == PROG) && (state != PROG)) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(ACK_TIMEOUT - 1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_idx   <= '0;
      step_req   <= 1'b0;
      lo2_rst_n  <= 1'b0;
      acq_valid  <= 1'b0;
      acq_last   <= 1'b0;
      step_done  <= 1'b0;
      sweep_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      step_idx   <= idx_nxt;
      step_req   <= (nxt == PROG);
      lo2_rst_n  <= (nxt == DWELL);
      acq_valid  <= (nxt == DWELL);
      acq_last   <= (nxt == DWELL) && cnt_zero_next;
      step_done  <= (nxt == NEXT);
      sweep_done <= (nxt == NEXT) && last_step;
      busy       <= (nxt != IDLE);
    end
  end

`ifdef SFCW_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sfcw_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sfcw_sweep_ctrl : scoreboard bench for sfcw_sweep_ctrl (N_STEPS=4,
// SETTLE_CYC=3, DWELL_CYC=20, ACK_TIMEOUT=8). Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sfcw_sweep_ctrl;

  localparam int N_STEPS  = 4;
  localparam int SETTLE   = 3;
  localparam int DWELL    = 20;
  localparam int ACK_TO   = 8;
  localparam int PROG_LEN = 2;
  localparam int STEP_LEN = PROG_LEN + SETTLE + DWELL + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req;
  logic [7:0] step_idx;
  logic       lo2_rst_n;
  logic       acq_valid;
  logic       acq_last;
  logic       step_done;
  logic       sweep_done;
  logic       busy;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int idx;
    bit sweep;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   ack_en = 1'b1;
  int   req_cnt = 0;
  int   settle_n = 0;
  int   dwell_n = 0;
  int   lo2_n = 0;
  int   last_at = 0;
  int   n;

  sfcw_sweep_ctrl #(
    .N_STEPS     (N_STEPS),
    .STEP_W      (8),
    .SETTLE_CYC  (SETTLE),
    .DWELL_CYC   (DWELL),
    .CNT_W       (16),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .step_req   (step_req),
    .step_idx   (step_idx),
    .step_ack   (step_ack),
    .lo2_rst_n  (lo2_rst_n),
    .acq_valid  (acq_valid),
    .acq_last   (acq_last),
    .step_done  (step_done),
    .sweep_done (sweep_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < N_STEPS; i++) begin
      exp_q.push_back('{idx: i, sweep: (i == N_STEPS - 1)});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit, output int cycles);
    cycles = busy ? 1 : 0;
    for (int i = 0; i < limit && busy; i++) begin
      @(negedge clk);
      if (busy) cycles++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait: busy=1 after %0d cycles, required 0", name, limit);
    end
  endtask

  task automatic wait_dwell(input string name, input int idx);
    for (int i = 0; i < 300 && !(acq_valid && step_idx == idx); i++) @(negedge clk);
    check({name, "_dwell_reached"}, int'(acq_valid && step_idx == idx), 1);
  endtask

  // PLL model: acknowledges in the second cycle of each request.
  initial begin
    forever begin
      @(negedge clk);
      if (step_req && ack_en && !step_ack) begin
        req_cnt++;
        step_ack = (req_cnt >= 2);
      end else begin
        step_ack = 1'b0;
        if (!step_req) req_cnt = 0;
      end
    end
  end

  // Monitor: measures each step's phases and checks them against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (step_req) begin
          settle_n = 0;
          dwell_n  = 0;
          lo2_n    = 0;
          last_at  = 0;
        end
        if (busy && !step_req && !acq_valid && !step_done) settle_n++;
        if (acq_valid) begin
          dwell_n++;
          if (acq_last) last_at = dwell_n;
        end
        if (lo2_rst_n) lo2_n++;
        if (step_done) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_step_done: got step_done=1 at step_idx %0d, required 0", step_idx);
          end else begin
            mon_e = exp_q.pop_front();
            check("step_idx", int'(step_idx), mon_e.idx);
            check("sweep_done", int'(sweep_done), int'(mon_e.sweep));
            check("settle_cycles", settle_n, SETTLE);
            check("dwell_cycles", dwell_n, DWELL);
            check("lo2_high_cycles", lo2_n, DWELL);
            check("acq_last_position", last_at, DWELL);
          end
        end else if (sweep_done) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_sweep_done: got sweep_done=1 without step_done, required 0");
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at 600us, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", int'({step_req, lo2_rst_n, acq_valid, acq_last,
                               step_done, sweep_done, busy, err}), 0);
    check("reset_step_idx", int'(step_idx), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single sweep
    continuous = 1'b0;
    push_sweep();
    pulse_start();
    check("req_after_start", int'(step_req), 1);
    check("idx_first_req", int'(step_idx), 0);
    wait_idle("single", 400, n);
    check("single_busy_cycles", n, N_STEPS * STEP_LEN);
    check("single_end_idx", int'(step_idx), 0);
    check("single_end_req", int'(step_req), 0);
    check("single_queue_drained", exp_q.size(), 0);

    // Continuous: restart at step 0 after the first sweep
    continuous = 1'b1;
    push_sweep();
    push_sweep();
    pulse_start();
    for (int i = 0; i < 300 && !sweep_done; i++) @(negedge clk);
    check("cont_first_sweep_done", int'(sweep_done), 1);
    @(negedge clk);
    check("cont_restart_req", int'(step_req), 1);
    check("cont_restart_idx", int'(step_idx), 0);
    continuous = 1'b0;
    wait_idle("continuous", 400, n);
    check("cont_queue_drained", exp_q.size(), 0);

    // Stop in dwell cycle 10 of step 2
    exp_q.push_back('{idx: 0, sweep: 1'b0});
    exp_q.push_back('{idx: 1, sweep: 1'b0});
    pulse_start();
    wait_dwell("stop", 2);
    repeat (9) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_lo2_rst_n", int'(lo2_rst_n), 0);
    check("stop_acq_valid", int'(acq_valid), 0);
    check("stop_step_done", int'(step_done), 0);
    check("stop_step_idx", int'(step_idx), 2);
    @(negedge clk);
    check("stop_queue_drained", exp_q.size(), 0);

    // start+stop together in IDLE is ignored
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", int'(busy), 0);
    check("startstop_req", int'(step_req), 0);
    check("startstop_idx", int'(step_idx), 2);

    // start while busy is ignored
    push_sweep();
    pulse_start();
    wait_dwell("busy_start", 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_acq_valid", int'(acq_valid), 1);
    check("busy_start_idx", int'(step_idx), 1);
    check("busy_start_req", int'(step_req), 0);
    wait_idle("busy_start", 400, n);
    check("busy_start_queue_drained", exp_q.size(), 0);

    // Reset (with stop also high) during SETTLE of step 1
    exp_q.push_back('{idx: 0, sweep: 1'b0});
    pulse_start();
    for (int i = 0; i < 200 && !(step_idx == 1 && busy && !step_req && !acq_valid && !step_done); i++)
      @(negedge clk);
    check("rst_settle_reached", int'(step_idx == 1 && busy && !step_req && !acq_valid), 1);
    rst  = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    check("rst_mid_flags", int'({step_req, lo2_rst_n, acq_valid, acq_last,
                                 step_done, sweep_done, busy, err}), 0);
    check("rst_mid_idx", int'(step_idx), 0);
    rst  = 1'b1;
    stop = 1'b0;
    @(negedge clk);
    check("rst_mid_stays_idle", int'(busy), 0);

`ifdef SFCW_ACK_TIMEOUT_EN
    // Ack never arrives: 8 PROG cycles, then err and IDLE
    ack_en = 1'b0;
    pulse_start();
    n = 0;
    for (int i = 0; i < 50 && step_req; i++) begin
      n++;
      @(negedge clk);
    end
    check("timeout_prog_cycles", n, ACK_TO);
    check("timeout_err", int'(err), 1);
    check("timeout_req", int'(step_req), 0);
    check("timeout_busy", int'(busy), 0);
    ack_en = 1'b1;
    push_sweep();
    pulse_start();
    wait_idle("after_timeout", 400, n);
    check("after_timeout_busy_cycles", n, N_STEPS * STEP_LEN);
    check("after_timeout_err_sticky", int'(err), 1);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
